sm_result_buffer: RTL and testbench

- Downstream consumer of the stack machine. Captures each d_valid result (pc, out_data, err_code) into a show-ahead FIFO for a slower reader (display/UART stage).
- Keeps running statistics: good/error result counts and signed sum of good results.
- Raises done once the machine has signalled fin and every captured entry has been read out.

---
 rtl/sm_result_buffer_if.sv | 36 +++
 rtl/sm_result_buffer.sv | 117 +++++++++++
 tb/tb_sm_result_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sm_result_buffer_if.sv
// Result-buffer bus: stack-machine result stream in, show-ahead reader port
// and statistics out.
interface sm_result_buffer_if #(
  parameter int AW = 4
);
  logic        d_valid;
  logic [9:0]  pc;
  logic [19:0] out_data;
  logic [2:0]  err_code;
  logic        fin;
  logic        rd_ready;

  logic        rd_valid;
  logic [9:0]  rd_pc;
  logic [19:0] rd_data;
  logic [2:0]  rd_err;
  logic [AW:0] count;
  logic        full;
  logic        overflow;
  logic [10:0] ok_cnt;
  logic [10:0] err_cnt;
  logic [31:0] sum;
  logic        done;

  modport master (
    output d_valid, pc, out_data, err_code, fin, rd_ready,
    input  rd_valid, rd_pc, rd_data, rd_err, count, full, overflow,
           ok_cnt, err_cnt, sum, done
  );

  modport slave (
    input  d_valid, pc, out_data, err_code, fin, rd_ready,
    output rd_valid, rd_pc, rd_data, rd_err, count, full, overflow,
           ok_cnt, err_cnt, sum, done
  );
endinterface

// File: rtl/sm_result_buffer.sv
// Show-ahead FIFO of stack-machine results with running statistics and a
// COLLECT/DRAIN/DONE sequencer that raises done once fin is seen and drained.
module sm_result_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic clk,
  input  logic rst_n,
  sm_result_buffer_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [32:0]     mem [DEPTH];
  logic [32:0]     head_q, head_d;
  logic [32:0]     wr_word;
  logic            overflow_q;
  logic [10:0]     ok_cnt_q, err_cnt_q;
  logic [31:0]     sum_q;

  logic            full, pop, accept, wr_en, drop;

  assign wr_word = {bus.pc, bus.out_data, bus.err_code};

  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = (count_q != '0) && bus.rd_ready;
    accept   = bus.d_valid && (state_q == COLLECT);
    wr_en    = accept && (!full || pop);
    drop     = accept && full && !pop;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
    // Next head is registered from the RAM; the slot being written this edge
    // is not in the RAM yet, so it is forwarded when it becomes the head.
    head_d = '0;
    if (count_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_word;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (bus.fin)        state_d = DRAIN;
      DRAIN:   if (count_q == '0)  state_d = DONE;
      DONE:                        state_d = DONE;
      default:                     state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      sum_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      // Statistics follow the whole result stream, including dropped entries.
      if (accept) begin
        if (bus.err_code == 3'd0) begin
          if (!(&ok_cnt_q)) ok_cnt_q <= ok_cnt_q + 11'd1;
          sum_q <= sum_q + {{12{bus.out_data[19]}}, bus.out_data};
        end else begin
          if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 11'd1;
        end
      end
    end
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_pc    = head_q[32:23];
  assign bus.rd_data  = head_q[22:3];
  assign bus.rd_err   = head_q[2:0];
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.ok_cnt   = ok_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.sum      = sum_q;
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_sm_result_buffer.sv
// Directed and randomized stimulus for sm_result_buffer, checked every cycle
// against a queue-based reference model.
module tb_sm_result_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [9:0]  pc;
    logic [19:0] data;
    logic [2:0]  err;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_result_buffer_if #(.AW(AW)) bus ();

  sm_result_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  entry_t      m_q[$];
  int          m_state;   // 0 collecting, 1 draining, 2 finished
  logic        m_ovf;
  int          m_ok, m_err;
  logic [31:0] m_sum;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    int     n;
    logic   pop;
    entry_t e;
    n   = m_q.size();
    pop = (n != 0) && bus.rd_ready;
    if (!rst_n) begin
      m_q.delete();
      m_state = 0; m_ovf = 1'b0; m_ok = 0; m_err = 0; m_sum = '0;
      return;
    end
    if (pop) begin
      e = m_q.pop_front();
      $display("pop pc=%0d data=%05h err=%0d", e.pc, e.data, e.err);
    end
    if (bus.d_valid && m_state == 0) begin
      if (bus.err_code == 3'd0) begin
        if (m_ok < 2047) m_ok++;
        m_sum = m_sum + 32'(signed'(bus.out_data));
      end else if (m_err < 2047) begin
        m_err++;
      end
      if (n < DEPTH || pop) m_q.push_back({bus.pc, bus.out_data, bus.err_code});
      else m_ovf = 1'b1;
    end
    if (m_state == 0 && bus.fin) m_state = 1;
    else if (m_state == 1 && n == 0) m_state = 2;
  endtask

  task automatic compare_all();
    entry_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    check("count",    64'(bus.count),    64'(m_q.size()));
    check("rd_valid", 64'(bus.rd_valid), 64'(m_q.size() != 0));
    check("rd_pc",    64'(bus.rd_pc),    64'(h.pc));
    check("rd_data",  64'(bus.rd_data),  64'(h.data));
    check("rd_err",   64'(bus.rd_err),   64'(h.err));
    check("full",     64'(bus.full),     64'(m_q.size() == DEPTH));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    check("ok_cnt",   64'(bus.ok_cnt),   64'(m_ok));
    check("err_cnt",  64'(bus.err_cnt),  64'(m_err));
    check("sum",      64'(bus.sum),      64'(m_sum));
    check("done",     64'(bus.done),     64'(m_state == 2));
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic cyc(input logic rn, input logic dv, input logic [9:0] p,
                     input logic [19:0] d, input logic [2:0] e,
                     input logic f, input logic rr);
    rst_n = rn; bus.d_valid = dv; bus.pc = p; bus.out_data = d;
    bus.err_code = e; bus.fin = f; bus.rd_ready = rr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [9:0] p, input logic [19:0] d, input logic [2:0] e, input logic rr);
    cyc(1'b1, 1'b1, p, d, e, 1'b0, rr);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, rr);
  endtask

  initial begin
    m_state = 0; m_ovf = 1'b0; m_ok = 0; m_err = 0; m_sum = '0;
    bus.d_valid = 1'b0; bus.pc = '0; bus.out_data = '0; bus.err_code = '0;
    bus.fin = 1'b0; bus.rd_ready = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();

    // Basic capture and ordered read-out
    push(10'd1, 20'd5, 3'd0, 1'b0);
    push(10'd2, 20'hFFFFD, 3'd0, 1'b0);
    push(10'd3, 20'h00000, 3'd3, 1'b0);
    check("basic_count", 64'(bus.count), 64'd3);
    check("basic_ok", 64'(bus.ok_cnt), 64'd2);
    check("basic_err", 64'(bus.err_cnt), 64'd1);
    check("basic_sum", 64'(bus.sum), 64'd2);
    check("basic_head", 64'(bus.rd_pc), 64'd1);
    idle(4, 1'b1);

    // Overflow: 17 writes into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) push(10'(i), 20'(i * 3), 3'd0, 1'b0);
    check("ovf_full", 64'(bus.full), 64'd1);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    check("ovf_count", 64'(bus.count), 64'd16);
    check("ovf_ok", 64'(bus.ok_cnt), 64'd17);
    idle(17, 1'b1);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 16; i++) push(10'(i + 100), 20'(i), 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 10'd99, 20'hABCDE, 3'd0, 1'b0, 1'b1);
    check("pp_count", 64'(bus.count), 64'd16);
    check("pp_ovf", 64'(bus.overflow), 64'd0);
    idle(17, 1'b1);

    // Finish with a simultaneous capture, then drain
    do_reset();
    push(10'd5, 20'd1, 3'd0, 1'b0);
    push(10'd6, 20'd2, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 10'd7, 20'd3, 3'd0, 1'b1, 1'b0);
    check("fin_count", 64'(bus.count), 64'd3);
    push(10'd8, 20'd4, 3'd0, 1'b0);
    check("fin_ignored_count", 64'(bus.count), 64'd3);
    check("fin_ignored_ok", 64'(bus.ok_cnt), 64'd3);
    idle(3, 1'b1);
    check("fin_not_done_yet", 64'(bus.done), 64'd0);
    idle(3, 1'b1);
    check("fin_done", 64'(bus.done), 64'd1);

    // Reset in the middle of a drain returns to collecting
    do_reset();
    push(10'd1, 20'd1, 3'd1, 1'b0);
    push(10'd2, 20'd1, 3'd0, 1'b0);
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    do_reset();
    check("rst_count", 64'(bus.count), 64'd0);
    push(10'd9, 20'd9, 3'd0, 1'b0);
    check("rst_recapture", 64'(bus.count), 64'd1);

    // Counter saturation and sum wrap
    do_reset();
    for (int i = 0; i < 2100; i++) push(10'(i), 20'd1, 3'd0, 1'b1);
    check("sat_ok", 64'(bus.ok_cnt), 64'd2047);
    check("sat_sum", 64'(bus.sum), 64'd2100);
    do_reset();
    for (int i = 0; i < 8192; i++) push(10'(i), 20'h7FFFF, 3'd0, 1'b0);
    check("wrap_sum", 64'(bus.sum), 64'hFFFFE000);

    // Randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        cyc(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 1) == 1),
            10'($urandom), 20'($urandom),
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
            ($urandom_range(0, 149) == 0),
            ($urandom_range(0, 9) < 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
